// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transaction state encoding, protocol constants and
// a saturating bit-counter helper used by the host transmitter and deserialiser.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_ACK,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;
  localparam int         PS2_FRAME_BITS = 11;

  // Counter holds at its maximum so a runaway clock cannot wrap it inside a frame.
  function automatic logic [3:0] sat_inc(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// Device-to-host frame deserialiser: the owning FSM supplies the frame phase each
// falling edge; this block checks start/parity/stop and shifts the payload LSB first.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 Mouse_Clk,
  input  logic                 reset,
  input  logic                 Mouse_Data,
  input  ps2_state_e           phase,
  output logic [DATA_BITS-1:0] frame_byte,
  output logic                 frame_err,
  output logic                 frame_err_next
);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(negedge Mouse_Clk or posedge reset) begin
    if (reset) begin
      frame_byte <= '0;
      frame_err  <= 1'b0;
    end else begin
      case (phase)
        RX_START: begin
          frame_byte <= '0;
          frame_err  <= Mouse_Data;
        end
        RX_DATA:   frame_byte <= {Mouse_Data, frame_byte[DATA_BITS-1:1]};
        RX_PARITY: if (~^{frame_byte, Mouse_Data}) frame_err <= 1'b1;
        RX_STOP:   if (!Mouse_Data) frame_err <= 1'b1;
        default:   ;
      endcase
    end
  end

  // Stop-bit verdict folded in combinationally so the owner can publish on the stop edge.
  assign frame_err_next = frame_err | ((phase == RX_STOP) & ~Mouse_Data);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter clocked by the mouse clock line:
// start bit, LSB-first payload, odd parity, stop, ACK check and one-byte reply capture.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int                   DATA_BITS       = 8,
  parameter bit                   EXPECT_RESPONSE = 1'b1,
  parameter logic [DATA_BITS-1:0] RESP_ACK_CODE   = 8'hFA
) (
  input  logic                 Mouse_Clk,
  input  logic                 reset,
  input  logic                 Mouse_Data,
  input  logic                 cmd_valid,
  input  logic [DATA_BITS-1:0] cmd_byte,
  output logic                 data_pull_low,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 ack_ok,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_byte,
  output logic                 resp_err,
  output logic                 resp_is_ack
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  ps2_state_e           state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_parity_q, tx_parity_d;
  logic                 cmd_valid_q;

  logic                 pull_d, busy_d, tx_done_d, ack_ok_d;
  logic                 resp_valid_d, resp_err_d, resp_is_ack_d;
  logic [DATA_BITS-1:0] resp_byte_d;

  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_err;
  logic                 rx_err_next;

  ps2_frame_rx #(
    .DATA_BITS(DATA_BITS)
  ) u_frame_rx (
    .Mouse_Clk     (Mouse_Clk),
    .reset         (reset),
    .Mouse_Data    (Mouse_Data),
    .phase         (state_q),
    .frame_byte    (rx_byte),
    .frame_err     (rx_err),
    .frame_err_next(rx_err_next)
  );

  // NOTE: every signal assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    tx_parity_d   = tx_parity_q;
    pull_d        = 1'b0;
    busy_d        = busy;
    tx_done_d     = tx_done;
    ack_ok_d      = ack_ok;
    resp_valid_d  = resp_valid;
    resp_byte_d   = resp_byte;
    resp_err_d    = resp_err;
    resp_is_ack_d = resp_is_ack;

    case (state_q)
      IDLE: begin
        // Rising request level only; streaming edges and a held request are ignored.
        if (cmd_valid && !cmd_valid_q) begin
          tx_shift_d    = cmd_byte;
          tx_parity_d   = ~^cmd_byte;
          bit_cnt_d     = 4'd0;
          tx_done_d     = 1'b0;
          ack_ok_d      = 1'b0;
          resp_valid_d  = 1'b0;
          resp_err_d    = 1'b0;
          resp_is_ack_d = 1'b0;
          busy_d        = 1'b1;
          pull_d        = 1'b1;
          state_d       = TX_DATA;
        end
      end
      TX_DATA: begin
        pull_d     = ~tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = 4'd0;
          state_d   = TX_PARITY;
        end else begin
          bit_cnt_d = sat_inc(bit_cnt_q);
        end
      end
      TX_PARITY: begin
        pull_d  = ~tx_parity_q;
        state_d = TX_STOP;
      end
      TX_STOP: state_d = TX_ACK;
      TX_ACK: begin
        ack_ok_d  = ~Mouse_Data;
        tx_done_d = 1'b1;
        if (!Mouse_Data && EXPECT_RESPONSE) begin
          state_d = RX_START;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RX_START: begin
        bit_cnt_d = 4'd0;
        state_d   = RX_DATA;
      end
      RX_DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = 4'd0;
          state_d   = RX_PARITY;
        end else begin
          bit_cnt_d = sat_inc(bit_cnt_q);
        end
      end
      RX_PARITY: state_d = RX_STOP;
      RX_STOP: begin
        resp_byte_d   = rx_byte;
        resp_valid_d  = 1'b1;
        resp_err_d    = rx_err_next;
        resp_is_ack_d = (rx_byte == RESP_ACK_CODE) && !rx_err_next;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge Mouse_Clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      tx_shift_q    <= '0;
      tx_parity_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      data_pull_low <= 1'b0;
      busy          <= 1'b0;
      tx_done       <= 1'b0;
      ack_ok        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_byte     <= '0;
      resp_err      <= 1'b0;
      resp_is_ack   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      tx_parity_q   <= tx_parity_d;
      cmd_valid_q   <= cmd_valid;
      data_pull_low <= pull_d;
      busy          <= busy_d;
      tx_done       <= tx_done_d;
      ack_ok        <= ack_ok_d;
      resp_valid    <= resp_valid_d;
      resp_byte     <= resp_byte_d;
      resp_err      <= resp_err_d;
      resp_is_ack   <= resp_is_ack_d;
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter for the Basys3 mouse interface; sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset) and captures the mouse's one-byte reply (normally 0xFA).
- Runs entirely on the mouse clock line.
- The system-clock mouse controller owns the ≥100 µs clock-inhibit and pairs it with cmd_valid. This block handles the start bit, serialisation, parity, ACK check and response capture.
- Its open-drain data request feeds the top-level IOBUF alongside the existing packet decoder.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- EXPECT_RESPONSE, 1, when 1 capture one device-to-host reply frame after the ACK; when 0 finish at the ACK.
- RESP_ACK_CODE, 8'hFA, reply value that sets resp_is_ack.

Ports:
- Mouse_Clk, input, 1, sensed PS/2 clock line; includes the controller's inhibit edge.
- reset, input, 1, asynchronous active-high reset.
- Mouse_Data, input, 1, sensed PS/2 data line.
- cmd_valid, input, 1, command request level from the controller; held from before the inhibit until busy is seen.
- cmd_byte, input, DATA_BITS, command; stable while cmd_valid=1.
- data_pull_low, output, 1, 1 = drive data line low; 0 = release (line reads 1).
- busy, output, 1, transaction in progress.
- tx_done, output, 1, command phase finished; held until next start.
- ack_ok, output, 1, device ACK sampled low; held.
- resp_valid, output, 1, reply frame captured; held.
- resp_byte, output, DATA_BITS, captured reply.
- resp_err, output, 1, reply start, parity or stop error; held.
- resp_is_ack, output, 1, resp_valid and resp_byte == RESP_ACK_CODE.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock Mouse_Clk.
- All state updates on the falling edge of Mouse_Clk.
- Reset values:
  - state IDLE.
  - data_pull_low, busy, tx_done, ack_ok, resp_valid, resp_err, resp_is_ack all 0.
  - resp_byte 0, cmd_valid_q 0.
- Reset mid-transfer releases the data line immediately.
- cmd_valid_q samples cmd_valid on every falling edge.
- Start condition: in IDLE with cmd_valid=1 and cmd_valid_q=0. Edges with cmd_valid=0 (mouse streaming) are ignored in IDLE.
- Edge E0 (the inhibit edge):
  - latch cmd_byte into the shift register; compute parity = ~^cmd_byte (odd parity).
  - clear tx_done, ack_ok, resp_valid, resp_err, resp_is_ack.
  - set busy=1 and data_pull_low=1 (start bit); enter TX_DATA.
- TX_DATA, E1..E8: data_pull_low = ~bit[n], n = 0..7, LSB first; shift right each edge.
- TX_PARITY, E9: data_pull_low = ~parity.
- TX_STOP, E10: data_pull_low = 0 (stop = 1, line released).
- TX_ACK, E11:
  - ack_ok = ~Mouse_Data; set tx_done=1.
  - If ack_ok=0 (NACK), go to IDLE with busy=0 regardless of EXPECT_RESPONSE.
  - Otherwise go to RX_START if EXPECT_RESPONSE=1, else go to IDLE with busy=0.
- RX_START, E12: Mouse_Data must be 0; otherwise set err flag.
- RX_DATA, E13..E20: shift Mouse_Data in LSB first.
- RX_PARITY, E21: require ^{data, Mouse_Data} == 1.
- RX_STOP, E22: require Mouse_Data == 1.
- On E22 update:
  - resp_byte = captured byte; resp_valid=1.
  - resp_err = OR of start, parity and stop errors.
  - resp_is_ack = (byte == RESP_ACK_CODE) & ~resp_err.
  - busy=0; go to IDLE.
- data_pull_low is 0 in every state except E0..E9.
- A 4-bit bit counter saturates; no wrap inside a frame.
- No timeout: a stalled mouse clock leaves the block in place. Recovery is by reset, issued by the controller's watchdog.
- A new command is not accepted until IDLE.
- cmd_valid held high after a transaction does not retrigger, because a rising level is required.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, TX_DATA, TX_PARITY, TX_STOP, TX_ACK, RX_START, RX_DATA, RX_PARITY, RX_STOP).
  - constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_RESP_ACK=8'hFA, PS2_FRAME_BITS=11.
- One sub-module: ps2_frame_rx (start/8-bit/parity/stop deserialiser with error flag). It is reused later to clean up the packet decoder.

Test Plan:
- cmd 0xF4, mouse ACK low at E11, reply 0xFA (parity bit 1, stop 1):
  - data_pull_low at E0..E10 = 1, 1,1,0,1,0,0,0,0, 1, 0.
  - ack_ok=1, resp_byte=0xFA, resp_is_ack=1, resp_err=0, busy=0 after E22.
- cmd 0xFF: parity bit 1 gives data_pull_low=0 at E9. Reply 0xFE with a bad parity bit gives resp_valid=1, resp_err=1, resp_is_ack=0.
- NACK: Mouse_Data=1 at E11 gives tx_done=1, ack_ok=0, busy=0, no RX phase; the following 11 clocks are ignored with cmd_valid=0.
- Retrigger guard: cmd_valid held 1 through the end of a transaction plus 5 extra edges gives no new start. Drop to 0, then raise with 0xF4 at the next edge; the transaction starts at that edge.
- Streaming edges with cmd_valid=0 in IDLE: data_pull_low stays 0 and busy stays 0 for 33 edges.
- Assert reset at E5: data_pull_low=0, busy=0 and all flags 0 immediately. A subsequent full 0xF4 transaction is correct.
